// File: rtl/kv_count_table.sv
// Register-based associative key/count table: single-cycle lookup with increment or insert,
// drop accounting and a streamed dump with optional clear. Define KV_COUNT_SATURATE_EN to clamp counts.
module kv_count_table #(
  parameter int KEY_W  = 128,
  parameter int CNT_W  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [KEY_W-1:0]  in_key,
  input  logic [CNT_W-1:0]  in_weight,
  output logic              upd_we,
  output logic [ADDR_W-1:0] upd_addr,
  output logic [CNT_W-1:0]  upd_count,
  output logic              upd_new,
  output logic              overflow,
  output logic [15:0]       drop_count,
  output logic [ADDR_W:0]   used,
  input  logic              dump_kick,
  input  logic              dump_clear,
  output logic              busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [KEY_W-1:0]  dump_key,
  output logic [CNT_W-1:0]  dump_count,
  output logic              dump_last
);

  // Handshakes: a key transfers on in_valid && in_ready; a dump beat on dump_valid && dump_ready.
  typedef enum logic {S_RUN = 1'b0, S_DUMP = 1'b1} state_t;

  state_t             state;
  logic [KEY_W-1:0]   keys [DEPTH];
  logic [CNT_W-1:0]   cnts [DEPTH];
  logic [DEPTH-1:0]   vld;
  logic [ADDR_W-1:0]  idx;
  logic               clear_lat;

  logic               accept;
  logic               full;
  logic               hit;
  logic [ADDR_W-1:0]  hit_idx;
  logic [CNT_W-1:0]   hit_cnt;
  logic [CNT_W:0]     sum_w;
  logic [CNT_W-1:0]   sum;
  logic [ADDR_W-1:0]  used_idx;
  logic [ADDR_W-1:0]  idx_nxt;
  logic [ADDR_W:0]    idx_nxt_ext;

  assign accept      = in_valid && in_ready;
  assign full        = (used == (ADDR_W+1)'(DEPTH));
  assign used_idx    = used[ADDR_W-1:0];
  assign idx_nxt     = idx + 1'b1;
  assign idx_nxt_ext = {1'b0, idx} + 1'b1;

  // Uniqueness of keys means at most one entry can match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && keys[i] == in_key) begin
        hit     = 1'b1;
        hit_idx = ADDR_W'(i);
        hit_cnt = cnts[i];
      end
    end
  end

  always_comb begin
    sum_w = {1'b0, hit_cnt} + {1'b0, in_weight};
`ifdef KV_COUNT_SATURATE_EN
    sum = sum_w[CNT_W] ? {CNT_W{1'b1}} : sum_w[CNT_W-1:0];
`else
    sum = sum_w[CNT_W-1:0];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_RUN;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      upd_we     <= 1'b0;
      upd_addr   <= '0;
      upd_count  <= '0;
      upd_new    <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
      used       <= '0;
      vld        <= '0;
      idx        <= '0;
      clear_lat  <= 1'b0;
      dump_valid <= 1'b0;
      dump_key   <= '0;
      dump_count <= '0;
      dump_last  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        keys[i] <= '0;
        cnts[i] <= '0;
      end
    end else begin
      upd_we   <= 1'b0;
      overflow <= 1'b0;
      case (state)
        S_RUN: begin
          if (accept) begin
            if (hit) begin
              cnts[hit_idx] <= sum;
              upd_we        <= 1'b1;
              upd_addr      <= hit_idx;
              upd_new       <= 1'b0;
              upd_count     <= sum;
            end else if (!full) begin
              keys[used_idx] <= in_key;
              cnts[used_idx] <= in_weight;
              vld[used_idx]  <= 1'b1;
              used           <= used + 1'b1;
              upd_we         <= 1'b1;
              upd_addr       <= used_idx;
              upd_new        <= 1'b1;
              upd_count      <= in_weight;
            end else begin
              overflow <= 1'b1;
              if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
          end
          // The same-cycle input lands at this edge, so the dump sees it.
          if (dump_kick) begin
            clear_lat <= dump_clear;
            idx       <= '0;
            state     <= S_DUMP;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_DUMP: begin
          if (!dump_valid) begin
            if (used == '0) begin
              state    <= S_RUN;
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end else begin
              dump_valid <= 1'b1;
              dump_key   <= keys[idx];
              dump_count <= cnts[idx];
              dump_last  <= (idx_nxt_ext == used);
            end
          end else if (dump_ready) begin
            if (dump_last) begin
              dump_valid <= 1'b0;
              dump_last  <= 1'b0;
              if (clear_lat) begin
                used <= '0;
                vld  <= '0;
              end
              state    <= S_RUN;
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end else begin
              idx        <= idx_nxt;
              dump_key   <= keys[idx_nxt];
              dump_count <= cnts[idx_nxt];
              dump_last  <= ((idx_nxt_ext + 1'b1) == used);
            end
          end
        end
        default: begin
          state    <= S_RUN;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
